// File: rtl/bf_prog_loader.sv
// Source-text loader for the brainhack program memory: filters ASCII command
// bytes, encodes them to 3-bit opcodes, validates brackets/length and appends halt.
module bf_prog_loader #(
  parameter int ADDR_W  = 8,
  parameter int DEPTH_W = 4
) (
  input  logic              i_clock,
  input  logic              i_reset_n,
  input  logic              i_start,
  input  logic              i_byte_valid,
  input  logic [7:0]        i_byte,
  output logic              o_byte_ready,
  output logic              o_prgmem_we,
  output logic [ADDR_W-1:0] o_prgmem_addr,
  output logic [2:0]        o_prgmem_data,
  output logic              o_busy,
  output logic              o_done,
  output logic [2:0]        o_error,
  output logic [ADDR_W:0]   o_length,
  output logic [2:0]        o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_TERM = 3'd2,
    S_DONE = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  localparam logic [2:0] ERR_STRAY    = 3'd1;
  localparam logic [2:0] ERR_NEST     = 3'd2;
  localparam logic [2:0] ERR_LONG     = 3'd3;
  localparam logic [2:0] ERR_UNCLOSED = 3'd4;

  localparam logic [DEPTH_W-1:0] DEPTH_MAX = '1;
  localparam logic [ADDR_W-1:0]  COUNT_MAX = '1;

  state_t              state;
  logic [ADDR_W-1:0]   count;
  logic [DEPTH_W-1:0]  depth;
  logic                is_cmd;
  logic                is_term;
  logic                is_open;
  logic                is_close;
  logic [2:0]          opcode;
  logic                xfer;

  // Handshake: a byte is consumed on a rising edge where i_byte_valid and
  // o_byte_ready are both high; o_byte_ready is high only in LOAD.
  assign o_byte_ready = (state == S_LOAD);
  assign o_busy       = (state == S_LOAD) || (state == S_TERM);
  assign o_length     = {1'b0, count};
  assign o_dbg_state  = state;
  assign xfer         = i_byte_valid && (state == S_LOAD);

  always_comb begin
    is_cmd   = 1'b1;
    is_term  = 1'b0;
    opcode   = 3'b000;
    case (i_byte)
      8'h2B:   opcode = 3'b011;
      8'h2D:   opcode = 3'b010;
      8'h3E:   opcode = 3'b101;
      8'h3C:   opcode = 3'b100;
      8'h5B:   opcode = 3'b111;
      8'h5D:   opcode = 3'b110;
      8'h00, 8'h21: begin
        is_cmd  = 1'b0;
        is_term = 1'b1;
      end
      default: is_cmd = 1'b0;
    endcase
    is_open  = is_cmd && (opcode == 3'b111);
    is_close = is_cmd && (opcode == 3'b110);
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state         <= S_IDLE;
      count         <= '0;
      depth         <= '0;
      o_prgmem_we   <= 1'b0;
      o_prgmem_addr <= '0;
      o_prgmem_data <= 3'b000;
      o_done        <= 1'b0;
      o_error       <= 3'd0;
    end else begin
      o_prgmem_we <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (i_start) begin
            state   <= S_LOAD;
            count   <= '0;
            depth   <= '0;
            o_error <= 3'd0;
            o_done  <= 1'b0;
          end
        end
        S_LOAD: begin
          if (xfer) begin
            if (is_term) begin
              o_prgmem_we   <= 1'b1;
              o_prgmem_addr <= count;
              o_prgmem_data <= 3'b000;
              state         <= S_TERM;
            end else if (is_cmd) begin
              // Error checks see pre-transfer values and suppress the write;
              // the last address is always reserved for the halt opcode.
              if (is_close && depth == '0) begin
                o_error <= ERR_STRAY;
                state   <= S_ERR;
              end else if (is_open && depth == DEPTH_MAX) begin
                o_error <= ERR_NEST;
                state   <= S_ERR;
              end else if (count == COUNT_MAX) begin
                o_error <= ERR_LONG;
                state   <= S_ERR;
              end else begin
                o_prgmem_we   <= 1'b1;
                o_prgmem_addr <= count;
                o_prgmem_data <= opcode;
                count         <= count + 1'b1;
                if (is_open)  depth <= depth + 1'b1;
                if (is_close) depth <= depth - 1'b1;
              end
            end
          end
        end
        S_TERM: begin
          if (depth == '0) begin
            o_done <= 1'b1;
            state  <= S_DONE;
          end else begin
            o_error <= ERR_UNCLOSED;
            state   <= S_ERR;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bf_prog_loader.sv
// Directed bench for bf_prog_loader: a source-level model predicts every
// memory write and the final status of each load, for ADDR_W=8 and ADDR_W=4.
module tb_bf_prog_loader;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       valid;
  logic [7:0] byte_in;
  logic       sel;

  logic       w0_ready, w0_we, w0_busy, w0_done;
  logic [7:0] w0_addr;
  logic [2:0] w0_data, w0_error, w0_state;
  logic [8:0] w0_len;
  logic       w1_ready, w1_we, w1_busy, w1_done;
  logic [3:0] w1_addr;
  logic [2:0] w1_data, w1_error, w1_state;
  logic [4:0] w1_len;

  bf_prog_loader #(.ADDR_W(8), .DEPTH_W(4)) dut (
    .i_clock(clk), .i_reset_n(rst_n), .i_start(start & ~sel),
    .i_byte_valid(valid & ~sel), .i_byte(byte_in),
    .o_byte_ready(w0_ready), .o_prgmem_we(w0_we), .o_prgmem_addr(w0_addr),
    .o_prgmem_data(w0_data), .o_busy(w0_busy), .o_done(w0_done),
    .o_error(w0_error), .o_length(w0_len), .o_dbg_state(w0_state)
  );

  bf_prog_loader #(.ADDR_W(4), .DEPTH_W(4)) dut_small (
    .i_clock(clk), .i_reset_n(rst_n), .i_start(start & sel),
    .i_byte_valid(valid & sel), .i_byte(byte_in),
    .o_byte_ready(w1_ready), .o_prgmem_we(w1_we), .o_prgmem_addr(w1_addr),
    .o_prgmem_data(w1_data), .o_busy(w1_busy), .o_done(w1_done),
    .o_error(w1_error), .o_length(w1_len), .o_dbg_state(w1_state)
  );

  logic       obs_ready, obs_we, obs_busy, obs_done;
  logic [7:0] obs_addr;
  logic [2:0] obs_data, obs_error, obs_state;
  logic [8:0] obs_len;

  assign obs_ready = sel ? w1_ready : w0_ready;
  assign obs_we    = sel ? w1_we    : w0_we;
  assign obs_busy  = sel ? w1_busy  : w0_busy;
  assign obs_done  = sel ? w1_done  : w0_done;
  assign obs_addr  = sel ? {4'b0, w1_addr} : w0_addr;
  assign obs_data  = sel ? w1_data  : w0_data;
  assign obs_error = sel ? w1_error : w0_error;
  assign obs_state = sel ? w1_state : w0_state;
  assign obs_len   = sel ? {4'b0, w1_len} : w0_len;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // model: 0 idle, 1 loading, 2 done, 3 error
  int m_aw;
  int m_state;
  int m_count;
  int m_depth;
  int m_err;
  logic [10:0] exp_q[$];
  logic [10:0] wr_log[$];

  function automatic int op_of(input logic [7:0] b);
    case (b)
      "+": return 3;
      "-": return 2;
      ">": return 5;
      "<": return 4;
      "[": return 7;
      "]": return 6;
      default: return -1;
    endcase
  endfunction

  task automatic model_accept(input logic [7:0] b);
    int op;
    if (m_state != 1) return;
    if (b == 8'h00 || b == 8'h21) begin
      exp_q.push_back({m_count[7:0], 3'b000});
      m_state = (m_depth == 0) ? 2 : 3;
      m_err   = (m_depth == 0) ? 0 : 4;
      return;
    end
    op = op_of(b);
    if (op < 0) return;
    if (b == "]" && m_depth == 0) begin m_state = 3; m_err = 1; end
    else if (b == "[" && m_depth == 15) begin m_state = 3; m_err = 2; end
    else if (m_count == (1 << m_aw) - 1) begin m_state = 3; m_err = 3; end
    else begin
      exp_q.push_back({m_count[7:0], op[2:0]});
      m_count++;
      if (b == "[") m_depth++;
      if (b == "]") m_depth--;
    end
  endtask

  // scoreboard: every write strobe must match the next predicted write
  always @(negedge clk) begin
    if (obs_we) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {obs_addr, obs_data}, -1);
      end else begin
        logic [10:0] e;
        e = exp_q.pop_front();
        check("write_addr_data", int'({obs_addr, obs_data}), int'(e));
      end
      wr_log.push_back({obs_addr, obs_data});
    end
  end

  // drivers (all called just after a rising edge)
  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    m_state = 0; m_count = 0; m_depth = 0; m_err = 0;
    exp_q.delete();
  endtask

  task automatic do_start();
    start = 1'b1;
    if (m_state != 1) begin
      m_state = 1; m_count = 0; m_depth = 0; m_err = 0;
    end
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    repeat (gap) begin @(posedge clk); #1; end
    valid   = 1'b1;
    byte_in = b;
    check("byte_ready", obs_ready, (m_state == 1) ? 1 : 0);
    if (obs_ready) model_accept(b);
    @(posedge clk); #1;
    valid = 1'b0;
  endtask

  task automatic send_str(input string s, input int maxgap);
    for (int i = 0; i < s.len(); i++) send(s[i], $urandom_range(0, maxgap));
  endtask

  task automatic finish_check(input string name);
    repeat (3) begin @(posedge clk); #1; end
    check({name, "_done"}, obs_done, (m_state == 2) ? 1 : 0);
    check({name, "_error"}, obs_error, m_err);
    check({name, "_busy"}, obs_busy, 0);
    check({name, "_ready"}, obs_ready, 0);
    check({name, "_pending_writes"}, exp_q.size(), 0);
    if (m_state == 2) check({name, "_length"}, obs_len, m_count);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_ready"}, obs_ready, 0);
    check({name, "_we"}, obs_we, 0);
    check({name, "_addr_data"}, {obs_addr, obs_data}, 0);
    check({name, "_busy"}, obs_busy, 0);
    check({name, "_done"}, obs_done, 0);
    check({name, "_error"}, obs_error, 0);
    check({name, "_length"}, obs_len, 0);
    check({name, "_state"}, obs_state, 0);
  endtask

  logic [2:0] t1_ops [8];

  initial begin
    start = 1'b0; valid = 1'b0; byte_in = 8'h00; sel = 1'b0; rst_n = 1'b0;
    m_aw = 8;
    #2;
    do_reset();
    check_all_zero("reset");

    // 1: basic loop program
    wr_log.delete();
    do_start();
    send_str("+[->+<]", 0);
    send("!", 0);
    finish_check("prog1");
    t1_ops = '{3'b011, 3'b111, 3'b010, 3'b101, 3'b011, 3'b100, 3'b110, 3'b000};
    check("prog1_write_count", wr_log.size(), 8);
    for (int i = 0; i < 8 && i < wr_log.size(); i++)
      check("prog1_literal_write", int'(wr_log[i]), int'({i[7:0], t1_ops[i]}));
    check("prog1_literal_length", obs_len, 7);

    // 2: ignored bytes with gaps, plus a start pulse that must be ignored
    wr_log.delete();
    do_start();
    send_str("a+ b", 3);
    do_start();
    send_str("\n-", 3);
    send(8'h00, 2);
    finish_check("filter");
    check("filter_write_count", wr_log.size(), 3);
    if (wr_log.size() == 3)
      check("filter_literal_last", int'(wr_log[2]), int'({8'd2, 3'b000}));
    check("filter_literal_length", obs_len, 2);

    // 3: stray close, then unclosed open
    wr_log.delete();
    do_start();
    send_str("]+", 0);
    finish_check("stray");
    check("stray_literal_error", obs_error, 1);
    check("stray_no_write", wr_log.size(), 0);
    do_start();
    send_str("[[+", 1);
    send(8'h00, 0);
    finish_check("unclosed");
    check("unclosed_literal_error", obs_error, 4);

    // 4: nesting overflow
    do_start();
    for (int i = 0; i < 16; i++) send("[", 0);
    send("!", 0);
    finish_check("nest");
    check("nest_literal_error", obs_error, 2);

    // 5: length overflow on the ADDR_W=4 instance
    sel = 1'b1; m_aw = 4;
    wr_log.delete();
    do_start();
    for (int i = 0; i < 16; i++) send("+", 0);
    finish_check("long");
    check("long_literal_error", obs_error, 3);
    check("long_write_count", wr_log.size(), 15);
    do_start();
    send_str("+>", 1);
    send("!", 0);
    finish_check("small_ok");

    // reset mid-stream aborts, restart is clean
    sel = 1'b0; m_aw = 8;
    do_start();
    send_str("+>+", 0);
    #2 rst_n = 1'b0;
    m_state = 0; m_count = 0; m_depth = 0; m_err = 0;
    exp_q.delete();
    #1;
    check_all_zero("midreset");
    @(posedge clk); #1 rst_n = 1'b1;
    wr_log.delete();
    do_start();
    send_str("<-", 2);
    send("!", 0);
    finish_check("restart");
    check("restart_literal_length", obs_len, 2);
    check("restart_write_count", wr_log.size(), 3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
